// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, fixed wait states,
// little-endian byte/half/word access with sign/zero extension and error flagging.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRW,
    input  logic [2:0]  RWType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ($clog2(WAIT_STATES + 1) > 1) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_rw;
    logic [2:0]      r_type;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [31:0]     r_rdata;
    logic            r_rsp_err;
    logic [7:0]      r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_rw;
    logic [2:0]            w_type;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] w_idx1;
    logic [ADDR_WIDTH-1:0] w_idx2;
    logic [ADDR_WIDTH-1:0] w_idx3;
    logic [31:0]           w_load;

    function automatic logic access_error(input logic rw, input logic [2:0] typ,
                                          input logic [31:0] a);
        logic bad_type;
        logic misal;
        logic oor;
        if (rw) begin
            bad_type = typ[2] | (typ[1:0] == 2'b11);
        end else begin
            bad_type = (typ[1:0] == 2'b11) | (typ == 3'b110);
        end
        case (typ[1:0])
            2'b01:   misal = a[0];
            2'b10:   misal = |a[1:0];
            default: misal = 1'b0;
        endcase
        oor = (a >> ADDR_WIDTH) != 32'd0;
        return bad_type | misal | oor;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] typ, input logic [31:0] raw);
        case (typ)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b010:  return raw;
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    assign w_accept = req_valid & r_req_ready;

    // With zero wait states the access commits on the accepting edge, so use live inputs in IDLE
    always_comb begin
        w_rw     = r_rw;
        w_type   = r_type;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_commit = 1'b0;
        if (r_state == S_IDLE) begin
            w_rw     = MemRW;
            w_type   = RWType;
            w_addr   = addr;
            w_wdata  = wdata;
            w_commit = w_accept && (WAIT_STATES == 0);
        end else if (r_state == S_WAIT) begin
            w_commit = (r_cnt == CW'(1));
        end else begin
            w_commit = 1'b0;
        end
    end

    assign w_err  = access_error(w_rw, w_type, w_addr);
    assign w_idx  = w_addr[ADDR_WIDTH-1:0];
    assign w_idx1 = w_idx + ADDR_WIDTH'(1);
    assign w_idx2 = w_idx + ADDR_WIDTH'(2);
    assign w_idx3 = w_idx + ADDR_WIDTH'(3);
    assign w_load = load_extend(w_type, {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx]});

    // Store commit: only the addressed bytes, never on a rejected access or during reset
    always_ff @(posedge clk) begin
        if (reset && w_commit && w_rw && !w_err) begin
            r_mem[w_idx] <= w_wdata[7:0];
            if (w_type[1:0] != 2'b00) begin
                r_mem[w_idx1] <= w_wdata[15:8];
            end
            if (w_type[1:0] == 2'b10) begin
                r_mem[w_idx2] <= w_wdata[23:16];
                r_mem[w_idx3] <= w_wdata[31:24];
            end
        end
    end

    // Request/response sequencing and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= CW'(0);
            r_rw        <= 1'b0;
            r_type      <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_rw        <= MemRW;
                        r_type      <= RWType;
                        r_addr      <= addr;
                        r_wdata     <= wdata;
                        r_cnt       <= CW'(WAIT_STATES);
                        r_req_ready <= 1'b0;
                        r_state     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_req_ready <= 1'b0;
                    r_cnt       <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rdata     <= (w_rw || w_err) ? 32'd0 : w_load;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rdata     = r_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
